// File: rtl/input_cond_pkg.sv
// Shared types and sizing helpers for the push-button / slide-switch debouncers.
package input_cond_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } ch_state_e;

  // ceil(log2(cycles)) + 1: the extra bit keeps headroom above DEBOUNCE_CYCLES-1.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(cycles)) w = i + 1;
    end
    return w + 1;
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_ch.sv
// One debounce channel: 2-flop synchronizer followed by a STABLE/COUNTING filter
// that accepts a new level only after DEBOUNCE_CYCLES consecutive mismatching samples.
//
// state    | meaning
// STABLE   | synced input agrees with the accepted level; counter idle at 0
// COUNTING | synced input disagrees; counting consecutive mismatching samples
module debounce_ch
  import input_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic din,
  output logic level,
  output logic change
);

  localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  ch_state_e      state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           level_q, level_d;
  logic           change_q, change_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q  <= RESET_VAL;
      sync2_q  <= RESET_VAL;
      state_q  <= STABLE;
      cnt_q    <= '0;
      level_q  <= RESET_VAL;
      change_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      change_q <= change_d;
    end
  end

  always_comb begin
    sync1_d  = din;
    sync2_d  = sync1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    change_d = 1'b0;
    case (state_q)
      STABLE: begin
        if (sync2_q != level_q) begin
          state_d = COUNTING;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      COUNTING: begin
        if (sync2_q == level_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          // Comparing with >= keeps the counter from ever running past the limit.
          level_d  = sync2_q;
          change_d = 1'b1;
          state_d  = STABLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level  = level_q;
  assign change = change_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces the active-low accumulate button and eight slide switches for the SoC PIOs;
// every output comes straight from channel flops, so raw inputs never reach an output combinationally.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       key_n,
  input  logic [7:0] sw,
  output logic       key_db_n,
  output logic       key_press,
  output logic [7:0] sw_db,
  output logic       sw_change
);

  logic       key_chg;
  logic [7:0] sw_chg;

  // Button idles released (high), so its channel resets to 1.
  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VAL      (1'b1)
  ) u_key_ch (
    .Clk   (Clk),
    .Reset (Reset),
    .din   (key_n),
    .level (key_db_n),
    .change(key_chg)
  );

  for (genvar i = 0; i < 8; i++) begin : g_sw_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b0)
    ) u_sw_ch (
      .Clk   (Clk),
      .Reset (Reset),
      .din   (sw[i]),
      .level (sw_db[i]),
      .change(sw_chg[i])
    );
  end

  assign key_press = key_chg & ~key_db_n;
  assign sw_change = |sw_chg;

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable cycles required to accept a new level (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have port Clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port key_n  input  1  raw asynchronous accumulate push-button, active-low.
REQ-005 SHALL have port sw  input  8  raw asynchronous slide switches.
REQ-006 SHALL have port key_db_n  output  1  debounced button level, active-low; drives the SoC accumulate-button PIO.
REQ-007 SHALL have port key_press  output  1  one-cycle pulse per accepted press (debounced 1->0).
REQ-008 SHALL have port sw_db  output  8  debounced switch levels; drives the SoC switch PIO.
REQ-009 SHALL have port sw_change  output  1  one-cycle pulse when any sw_db bit changes.

Function
REQ-010 Each of the 9 inputs SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each channel SHALL run an FSM with states STABLE and COUNTING, plus a counter of ceil(log2(DEBOUNCE_CYCLES))+1 bits.
REQ-012 STABLE: if synced input != debounced output, go to COUNTING with counter=1; otherwise stay, counter=0.
REQ-013 COUNTING, synced input == debounced output (bounce): return to STABLE, counter=0, output unchanged, no pulse.
REQ-014 COUNTING, mismatch and counter < DEBOUNCE_CYCLES-1: counter increments.
REQ-015 COUNTING, mismatch and counter == DEBOUNCE_CYCLES-1: debounced output takes the synced value, channel change pulse asserts for exactly one cycle at that same edge, return to STABLE, counter=0.
REQ-016 Latency: a clean level change first sampled at edge k SHALL appear on the debounced output at edge k+DEBOUNCE_CYCLES+1; any reversion before that restarts the count.
REQ-017 Counter SHALL never exceed DEBOUNCE_CYCLES-1; no wrap-around.
REQ-018 key_press SHALL equal key channel change pulse AND NOT key_db_n; releases produce no pulse.
REQ-019 sw_change SHALL be the OR of the 8 switch channel change pulses; simultaneous acceptances on several bits produce a single one-cycle pulse.
REQ-020 Channels SHALL be fully independent; simultaneous activity on all channels SHALL not delay any channel.
REQ-021 Pulses SHALL never exceed one cycle; a new pulse requires a new accepted transition.

Reset
REQ-022 While Reset is high at an edge: key_db_n=1, key sync flops=1, sw_db=0, sw sync flops=0, key_press=0, sw_change=0, all FSMs STABLE, counters 0.
REQ-023 Reset asserted mid-count SHALL abort the count with no output change and no pulse.
REQ-024 After reset, a switch held at 1 SHALL debounce normally to 1 and produce exactly one sw_change pulse; a button held pressed through reset SHALL produce exactly one key_press.

Structure
REQ-025 Package input_cond_pkg SHALL hold the channel state enum (STABLE, COUNTING) and the counter-width function.
REQ-026 One sub-module debounce_ch SHALL implement REQ-010..REQ-017 for one bit (parameters DEBOUNCE_CYCLES, RESET_VAL; outputs level and change pulse), instantiated 9 times.
REQ-027 No combinational path SHALL exist from key_n or sw to any output.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Reset, key_n=1, sw=0 held 20 cycles -> key_db_n=1, sw_db=0x00, no pulses.
REQ-029 key_n 1->0 sampled at edge 0, held -> key_db_n falls at edge 5, key_press high exactly one cycle at edge 5; release 0->1 -> key_db_n rises 5 edges later, no key_press.
REQ-030 key_n low 3 cycles, high 1, low 3, high -> key_db_n stays 1, no key_press.
REQ-031 sw 0x00->0xA5 in one cycle, held -> sw_db=0xA5 at edge 5, single sw_change pulse; then bit 0 toggles alone -> sw_db=0xA4, one further pulse.
REQ-032 key_n low for 3 cycles, Reset pulsed at cycle 3, key_n held low -> no output change during reset; key_db_n falls 5 edges after Reset deasserts, one key_press.
